exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Initiator side of the CP0 exception interface.
- Watches the instruction committing in the memory stage and collects its exception flags plus the CP0 interrupt status, then picks the single highest-priority event.
- Drives the CP0 exception and ERET strobes and issues a pipeline flush with a redirect PC to fetch.
- Sits between the memory stage, the CP0 block and the fetch unit.

Parameters:
- BEV_BASE, 32'hBFC00200, vector base used when Status.BEV=1.
- REFILL_OFF, 32'h000, offset for TLB refill taken with EXL=0.
- GEN_OFF, 32'h180, offset for all other exceptions and interrupts.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  memory-stage instruction is real and not killed
- mem_pc  in  32  its PC
- mem_bd  in  1  it sits in a branch delay slot
- mem_daddr  in  32  its data virtual address
- exc_vec  in  11  flags, bit order {if_adel, if_tlb_miss, if_tlb_inv, ri, sys, bp, ov, d_adel, d_ades, d_tlb_miss, d_tlb_inv_or_mod}
- d_is_store  in  1  data access is a store (selects TLBL/TLBS and Mod)
- d_mod  in  1  TLB dirty fault; used only with bit 0 of exc_vec
- eret  in  1  committing instruction is ERET
- allow_int, interrupt_flag[7:0], sr_exl, sr_bev, ebase[31:0], epc[31:0]  in  from CP0
- en_exp  out  1  one-cycle exception strobe to CP0
- exp_bd  out  1  delay-slot flag to CP0
- exp_epc  out  32  EPC value to CP0
- exc_code  out  5  ExcCode to CP0
- exp_badvaddr  out  32  bad virtual address to CP0
- exp_badvaddr_we  out  1  BadVAddr/Context/EntryHi update enable
- clear_exl  out  1  ERET strobe to CP0
- flush  out  1  kill every stage younger than writeback
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts the redirect

Behaviour:
- Reset: every output is 0; FSM starts in IDLE.
- Event selection in IDLE is combinational on the cycle-N inputs. All CP0-side outputs and redirect_pc are registered and appear in cycle N+1.
- An event happens only when mem_valid=1.
- Priority, high to low:
  - interrupt (allow_int & |interrupt_flag), code 0
  - if_adel, code 4
  - if_tlb_miss, code 2
  - if_tlb_inv, code 2
  - ri, code 10
  - sys, code 8
  - bp, code 9
  - ov, code 12
  - d_adel, code 4
  - d_ades, code 5
  - d_tlb_miss, code 2 or 3 by d_is_store
  - d_tlb_inv_or_mod: code 1 if d_mod, else 2 or 3 by d_is_store
  - eret (lowest)
- exp_epc:
  - sr_exl=0: mem_bd ? mem_pc-4 : mem_pc, with exp_bd=mem_bd.
  - sr_exl=1: exp_epc=epc and exp_bd=0, so the current EPC is preserved.
- BadVAddr:
  - Instruction-side address or TLB events: exp_badvaddr=mem_pc, exp_badvaddr_we=1.
  - Data-side address or TLB events: exp_badvaddr=mem_daddr, exp_badvaddr_we=1.
  - All other events: exp_badvaddr_we=0.
- Target:
  - base = sr_bev ? BEV_BASE : {ebase[31:12],12'h0}
  - if_tlb_miss or d_tlb_miss with sr_exl=0: base+REFILL_OFF
  - any other exception: base+GEN_OFF
  - eret: epc, with clear_exl=1 and en_exp=0
- FSM IDLE: on an event, go to REDIR. In cycle N+1 en_exp (or clear_exl) pulses for exactly one cycle, flush=1 and redirect_valid=1.
- FSM REDIR:
  - flush and redirect_valid stay high; redirect_pc is held stable.
  - Any new events are ignored, since the flushed stage is garbage.
  - When redirect_valid & redirect_ready, return to IDLE; flush drops the following cycle.
  - The ready may be high in cycle N+1, giving a single-cycle redirect.
- Simultaneous exception and eret: the exception wins and clear_exl stays 0.
- Simultaneous interrupt and synchronous exception: the interrupt wins, with exc_code=0 and EPC = the interrupted PC.
- Async reset mid-REDIR: the FSM returns to IDLE, all outputs drop to 0 immediately and the pending redirect is lost.
- Address arithmetic is 32-bit modulo; mem_pc-4 wraps at 0.

Decomposition:
- Shared package cpu_exc_pkg:
  - ExcCode localparams (EXC_INT, EXC_MOD, EXC_TLBL, EXC_TLBS, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV)
  - exc_vec bit-index localparams
  - the FSM enum {IDLE, REDIR}
- Sub-module exc_prio_enc: purely combinational priority encoder from exc_vec, interrupt, eret and d_is_store/d_mod to {hit, code, is_refill, badv_sel, is_eret}.

Test Plan:
- Syscall: mem_valid=1, sys=1, mem_pc=32'h8000_1000, mem_bd=0, sr_bev=0, ebase=32'h8000_0000 -> next cycle en_exp=1 for one cycle, exc_code=8, exp_epc=32'h8000_1000, redirect_pc=32'h8000_0180, exp_badvaddr_we=0.
- Delay-slot data TLB refill: mem_bd=1, mem_pc=32'h0040_0104, d_tlb_miss=1, d_is_store=1, mem_daddr=32'h1234_5678, sr_exl=0 -> exc_code=3, exp_epc=32'h0040_0100, exp_bd=1, badvaddr=32'h1234_5678 with we=1, redirect_pc=32'h8000_0000.
- Same refill with sr_exl=1 and epc=32'h8000_2000 -> redirect_pc=32'h8000_0180, exp_epc=32'h8000_2000, exp_bd=0.
- ERET with epc=32'hBFC0_0380 -> clear_exl=1 for one cycle, en_exp=0, redirect_pc=32'hBFC0_0380; interrupt plus ri in the same cycle -> exc_code=0.
- Redirect stall: redirect_ready=0 for 3 cycles -> flush and redirect_valid held for 4 cycles, a new sys during the stall is ignored, back to IDLE after ready.
- rst_n asserted mid-REDIR -> all outputs 0 immediately; sr_bev=1 ri -> redirect_pc=32'hBFC0_0380.

Source files
------------

// File: rtl/cpu_exc_pkg.sv
// Shared definitions for the CP0 exception initiator: ExcCodes, exc_vec bit
// positions, BadVAddr source selects and the redirect FSM states.
package cpu_exc_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int EV_IF_ADEL     = 10;
  localparam int EV_IF_TLB_MISS = 9;
  localparam int EV_IF_TLB_INV  = 8;
  localparam int EV_RI          = 7;
  localparam int EV_SYS         = 6;
  localparam int EV_BP          = 5;
  localparam int EV_OV          = 4;
  localparam int EV_D_ADEL      = 3;
  localparam int EV_D_ADES      = 2;
  localparam int EV_D_TLB_MISS  = 1;
  localparam int EV_D_TLB_INV   = 0;

  localparam logic [1:0] BADV_NONE  = 2'd0;
  localparam logic [1:0] BADV_PC    = 2'd1;
  localparam logic [1:0] BADV_DADDR = 2'd2;

  typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} exc_state_e;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the single winning event among the
// interrupt, the committing instruction's exception flags and ERET.
module exc_prio_enc
  import cpu_exc_pkg::*;
(
  input  logic        int_req,
  input  logic [10:0] exc_vec,
  input  logic        d_is_store,
  input  logic        d_mod,
  input  logic        eret,
  output logic        hit,
  output logic [4:0]  code,
  output logic        is_refill,
  output logic [1:0]  badv_sel,
  output logic        is_eret
);

  logic [4:0] d_tlb_code;

  assign d_tlb_code = d_is_store ? EXC_TLBS : EXC_TLBL;

  always_comb begin
    hit       = 1'b1;
    code      = EXC_INT;
    is_refill = 1'b0;
    badv_sel  = BADV_NONE;
    is_eret   = 1'b0;
    if (int_req) begin
      code = EXC_INT;
    end else if (exc_vec[EV_IF_ADEL]) begin
      code     = EXC_ADEL;
      badv_sel = BADV_PC;
    end else if (exc_vec[EV_IF_TLB_MISS]) begin
      code      = EXC_TLBL;
      is_refill = 1'b1;
      badv_sel  = BADV_PC;
    end else if (exc_vec[EV_IF_TLB_INV]) begin
      code     = EXC_TLBL;
      badv_sel = BADV_PC;
    end else if (exc_vec[EV_RI]) begin
      code = EXC_RI;
    end else if (exc_vec[EV_SYS]) begin
      code = EXC_SYS;
    end else if (exc_vec[EV_BP]) begin
      code = EXC_BP;
    end else if (exc_vec[EV_OV]) begin
      code = EXC_OV;
    end else if (exc_vec[EV_D_ADEL]) begin
      code     = EXC_ADEL;
      badv_sel = BADV_DADDR;
    end else if (exc_vec[EV_D_ADES]) begin
      code     = EXC_ADES;
      badv_sel = BADV_DADDR;
    end else if (exc_vec[EV_D_TLB_MISS]) begin
      code      = d_tlb_code;
      is_refill = 1'b1;
      badv_sel  = BADV_DADDR;
    end else if (exc_vec[EV_D_TLB_INV]) begin
      code     = d_mod ? EXC_MOD : d_tlb_code;
      badv_sel = BADV_DADDR;
    end else begin
      // ERET only wins when nothing synchronous or asynchronous is pending.
      hit     = 1'b0;
      is_eret = eret;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception initiator: registers the winning event into CP0 strobes and
// holds a flush plus redirect request until fetch accepts the new PC.
module exc_ctrl
  import cpu_exc_pkg::*;
#(
  parameter logic [31:0] BEV_BASE   = 32'hBFC00200,
  parameter logic [31:0] REFILL_OFF = 32'h000,
  parameter logic [31:0] GEN_OFF    = 32'h180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [31:0] mem_daddr,
  input  logic [10:0] exc_vec,
  input  logic        d_is_store,
  input  logic        d_mod,
  input  logic        eret,
  input  logic        allow_int,
  input  logic [7:0]  interrupt_flag,
  input  logic        sr_exl,
  input  logic        sr_bev,
  input  logic [31:0] ebase,
  input  logic [31:0] epc,
  output logic        en_exp,
  output logic        exp_bd,
  output logic [31:0] exp_epc,
  output logic [4:0]  exc_code,
  output logic [31:0] exp_badvaddr,
  output logic        exp_badvaddr_we,
  output logic        clear_exl,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        dbg_state
);

  logic        hit, is_refill, is_eret;
  logic [4:0]  code;
  logic [1:0]  badv_sel;
  logic [31:0] base, target;

  exc_state_e  state_q, state_d;
  logic        en_exp_q, en_exp_d, exp_bd_q, exp_bd_d;
  logic [31:0] exp_epc_q, exp_epc_d, badv_q, badv_d, rpc_q, rpc_d;
  logic [4:0]  code_q, code_d;
  logic        badv_we_q, badv_we_d, clr_q, clr_d;
  logic        flush_q, flush_d, rv_q, rv_d;

  exc_prio_enc u_prio (
    .int_req    (allow_int & (|interrupt_flag)),
    .exc_vec    (exc_vec),
    .d_is_store (d_is_store),
    .d_mod      (d_mod),
    .eret       (eret),
    .hit        (hit),
    .code       (code),
    .is_refill  (is_refill),
    .badv_sel   (badv_sel),
    .is_eret    (is_eret)
  );

  assign base   = sr_bev ? BEV_BASE : (ebase & 32'hFFFF_F000);
  assign target = base + ((is_refill && !sr_exl) ? REFILL_OFF : GEN_OFF);

  always_comb begin
    state_d   = state_q;
    en_exp_d  = 1'b0;
    clr_d     = 1'b0;
    badv_we_d = 1'b0;
    exp_bd_d  = exp_bd_q;
    exp_epc_d = exp_epc_q;
    code_d    = code_q;
    badv_d    = badv_q;
    rpc_d     = rpc_q;
    flush_d   = flush_q;
    rv_d      = rv_q;
    case (state_q)
      IDLE: begin
        if (mem_valid && (hit || is_eret)) begin
          state_d = REDIR;
          flush_d = 1'b1;
          rv_d    = 1'b1;
          rpc_d   = is_eret ? epc : target;
          clr_d   = is_eret;
          if (hit) begin
            en_exp_d  = 1'b1;
            code_d    = code;
            // With EXL already set the live EPC must survive the nested trap.
            exp_bd_d  = sr_exl ? 1'b0 : mem_bd;
            exp_epc_d = sr_exl ? epc : (mem_bd ? mem_pc - 32'd4 : mem_pc);
            badv_we_d = (badv_sel != BADV_NONE);
            if (badv_sel == BADV_PC) badv_d = mem_pc;
            else if (badv_sel == BADV_DADDR) badv_d = mem_daddr;
          end
        end
      end
      REDIR: begin
        if (rv_q && redirect_ready) begin
          state_d = IDLE;
          flush_d = 1'b0;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_exp_q  <= 1'b0;
      exp_bd_q  <= 1'b0;
      exp_epc_q <= 32'h0;
      code_q    <= 5'h0;
      badv_q    <= 32'h0;
      badv_we_q <= 1'b0;
      clr_q     <= 1'b0;
      flush_q   <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      en_exp_q  <= en_exp_d;
      exp_bd_q  <= exp_bd_d;
      exp_epc_q <= exp_epc_d;
      code_q    <= code_d;
      badv_q    <= badv_d;
      badv_we_q <= badv_we_d;
      clr_q     <= clr_d;
      flush_q   <= flush_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
    end
  end

  assign en_exp          = en_exp_q;
  assign exp_bd          = exp_bd_q;
  assign exp_epc         = exp_epc_q;
  assign exc_code        = code_q;
  assign exp_badvaddr    = badv_q;
  assign exp_badvaddr_we = badv_we_q;
  assign clear_exl       = clr_q;
  assign flush           = flush_q;
  assign redirect_valid  = rv_q;
  assign redirect_pc     = rpc_q;
  assign dbg_state       = (state_q == REDIR);

endmodule
